ie_muldiv_sequencer: RTL and testbench
======================================

Name: ie_muldiv_sequencer

Overview:
- Multi-cycle multiply/divide controller beside the execute-stage ALU, for RV32M-style unsigned ops.
- Accepts one operation from decode and runs an iterative shift-add multiply or restoring divide, one bit per cycle.
- Stalls the front of the pipeline while busy, then presents the result for one cycle so execute can register it in place of the ALU output.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- CNT_WIDTH, $clog2(DATA_WIDTH), iteration counter width. Derived; do not override.

Ports:
- i_clk  input  1  clock; all state on rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_start  input  1  request; sampled only in IDLE.
- i_op  input  2  operation: 0 MUL (low word), 1 MULHU (high word), 2 DIVU, 3 REMU.
- i_operand_a  input  DATA_WIDTH  rs1 value (multiplicand/dividend).
- i_operand_b  input  DATA_WIDTH  rs2 value (multiplier/divisor).
- i_flush  input  1  abort in-flight op (branch mispredict/trap).
- o_busy  output  1  high in CALC or DONE.
- o_stall  output  1  pipeline hold request.
- o_done  output  1  one-cycle result-valid strobe.
- o_result  output  DATA_WIDTH  selected result; held until the next accepted start.

Behaviour:
- Reset (async, active-high): state IDLE, counter 0, all internal registers 0. Outputs o_busy=0, o_stall=0, o_done=0, o_result=0. Reset mid-operation discards the op; no o_done follows.
- FSM states: IDLE, CALC, DONE.
- IDLE + i_start + !i_flush:
  - Latch i_op and both operands.
  - If the op is DIVU/REMU and i_operand_b==0: go directly to DONE.
  - Otherwise go to CALC with counter=0.
- Accumulators:
  - MUL/MULHU: 2*DATA_WIDTH-bit product register.
  - DIVU/REMU: DATA_WIDTH-bit quotient and DATA_WIDTH+1-bit partial remainder.
- CALC, one iteration per cycle:
  - Multiply: if multiplier LSB is set, add the multiplicand to the upper half of the product; then shift right 1, keeping the carry out.
  - Divide: shift the remainder left, bringing in the dividend MSB; trial-subtract the divisor; if non-negative keep the difference and shift 1 into the quotient, else shift 0.
  - Counter increments each cycle. When counter==DATA_WIDTH-1, go to DONE on that edge.
- DONE:
  - o_done=1 and o_result is valid.
  - Result by op: MUL low word, MULHU high word, DIVU quotient, REMU remainder.
  - Next edge always returns to IDLE.
- Divide-by-zero (RISC-V semantics): DIVU -> all ones; REMU -> i_operand_a.
- Latency, counted from the edge that samples i_start:
  - Normal op: o_done is high in the cycle after edge DATA_WIDTH+1 (33 edges for a 32-bit width).
  - Divide-by-zero: o_done after edge 1.
- Stall:
  - o_stall = (IDLE & i_start & !i_flush) | CALC. This is combinational on i_start so decode holds its instruction from the request cycle.
  - o_stall is low in DONE so the pipeline advances and captures o_result.
- i_start outside IDLE: ignored; no queueing.
- i_flush:
  - In CALC or DONE: next state IDLE, o_done suppressed that cycle, o_result keeps its previous value.
  - In IDLE: blocks acceptance even with i_start=1.
  - Flush beats start when both are asserted.
- o_result updates only on entry to DONE. o_done is never high for two consecutive cycles.
- Back-to-back ops: a new i_start is accepted in the IDLE cycle after DONE, so the minimum spacing between starts is DATA_WIDTH+2 cycles.
- Width rules:
  - All adds/subtracts are unsigned.
  - The multiply add carry is kept in the upper product bit.
  - The divide trial subtraction uses DATA_WIDTH+1 bits; its sign bit decides restore.

Decomposition:
- Package ie_muldiv_pkg:
  - enum muldiv_op_t {MD_MUL, MD_MULHU, MD_DIVU, MD_REMU} (2 bits).
  - enum muldiv_state_t {MD_IDLE, MD_CALC, MD_DONE}.
  - Divide-by-zero quotient constant (all ones).
- One sub-module is natural: muldiv_step, a combinational single-iteration step (mult add-shift / div subtract-shift). This keeps the FSM file sequential only.

Test Plan:
- MUL 7 x 6: start in IDLE -> o_stall=1 from the start cycle; o_done pulses 33 edges later with o_result=42; o_busy falls the next cycle.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> o_result=0xFFFFFFFE. Then MUL on the same operands, started the cycle after returning to IDLE -> o_result=0x00000001.
- DIVU 100/7 -> o_result=14; REMU 100/7 -> o_result=2. DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
- DIVU 5/0 -> o_done after 1 edge, o_result=0xFFFFFFFF. REMU 5/0 -> o_result=5, with no CALC cycles.
- Abort paths:
  - i_flush at CALC iteration 10 -> IDLE next edge; no o_done; o_result keeps its prior value.
  - i_start+i_flush together in IDLE -> not accepted.
  - i_start pulsed during CALC -> ignored.
- Assert i_reset asynchronously mid-CALC (between edges) -> outputs zero immediately. After release, DIVU 9/3 -> o_result=3 with normal 33-edge latency.

Source files
------------

// File: rtl/ie_muldiv_pkg.sv
// Shared types and constants for the iterative RV32M-style unsigned multiply/divide unit.
package ie_muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MUL   = 2'd0,
        MD_MULHU = 2'd1,
        MD_DIVU  = 2'd2,
        MD_REMU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } muldiv_state_t;

    // Wide enough for any supported DATA_WIDTH; users slice the low bits.
    localparam int MD_MAX_WIDTH = 64;
    localparam logic [MD_MAX_WIDTH-1:0] MD_DIV0_QUOT = '1;

    function automatic logic md_is_div(input muldiv_op_t op);
        return (op == MD_DIVU) || (op == MD_REMU);
    endfunction

endpackage

// File: rtl/ie_muldiv_sequencer_step.sv
// One combinational iteration: shift-add multiply step and restoring divide step, computed side by side.
module muldiv_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2*DATA_WIDTH-1:0] i_prod,
    input  logic [DATA_WIDTH-1:0]   i_mcand,
    input  logic [DATA_WIDTH-1:0]   i_quot,
    input  logic [DATA_WIDTH-1:0]   i_rem,
    input  logic [DATA_WIDTH-1:0]   i_divisor,
    output logic [2*DATA_WIDTH-1:0] o_prod,
    output logic [DATA_WIDTH-1:0]   o_quot,
    output logic [DATA_WIDTH-1:0]   o_rem
);

    logic [DATA_WIDTH:0] w_sum;
    logic [DATA_WIDTH:0] w_rem_sh;
    logic [DATA_WIDTH:0] w_diff;

    always_comb begin
        // Carry out of the upper-half add lands in the product MSB after the shift.
        w_sum = i_prod[0] ? ({1'b0, i_prod[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, i_mcand})
                          : {1'b0, i_prod[2*DATA_WIDTH-1:DATA_WIDTH]};
        o_prod = {w_sum, i_prod[DATA_WIDTH-1:1]};

        // Dividend bits shift out of the quotient register as quotient bits shift in.
        w_rem_sh = {i_rem, i_quot[DATA_WIDTH-1]};
        w_diff   = w_rem_sh - {1'b0, i_divisor};
        o_rem    = w_diff[DATA_WIDTH] ? w_rem_sh[DATA_WIDTH-1:0] : w_diff[DATA_WIDTH-1:0];
        o_quot   = {i_quot[DATA_WIDTH-2:0], ~w_diff[DATA_WIDTH]};
    end

endmodule

// File: rtl/ie_muldiv_sequencer.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU sequencer that stalls the front end while iterating.
module ie_muldiv_sequencer
    import ie_muldiv_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [1:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_operand_a,
    input  logic [DATA_WIDTH-1:0] i_operand_b,
    input  logic                  i_flush,
    output logic                  o_busy,
    output logic                  o_stall,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result
);

    localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DATA_WIDTH - 1);

    muldiv_state_t           r_state;
    muldiv_op_t              r_op;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [2*DATA_WIDTH-1:0] r_prod;
    logic [DATA_WIDTH-1:0]   r_mcand;
    logic [DATA_WIDTH-1:0]   r_quot;
    logic [DATA_WIDTH-1:0]   r_rem;
    logic [DATA_WIDTH-1:0]   r_divisor;
    logic [DATA_WIDTH-1:0]   r_result;

    logic [2*DATA_WIDTH-1:0] w_prod_next;
    logic [DATA_WIDTH-1:0]   w_quot_next;
    logic [DATA_WIDTH-1:0]   w_rem_next;
    logic [DATA_WIDTH-1:0]   w_final;
    logic                    w_accept;
    muldiv_op_t              w_op_in;

    muldiv_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .i_prod    (r_prod),
        .i_mcand   (r_mcand),
        .i_quot    (r_quot),
        .i_rem     (r_rem),
        .i_divisor (r_divisor),
        .o_prod    (w_prod_next),
        .o_quot    (w_quot_next),
        .o_rem     (w_rem_next)
    );

    assign w_op_in  = muldiv_op_t'(i_op);
    assign w_accept = (r_state == MD_IDLE) && i_start && !i_flush;

    always_comb begin
        w_final = '0;
        case (r_op)
            MD_MUL:   w_final = w_prod_next[DATA_WIDTH-1:0];
            MD_MULHU: w_final = w_prod_next[2*DATA_WIDTH-1:DATA_WIDTH];
            MD_DIVU:  w_final = w_quot_next;
            MD_REMU:  w_final = w_rem_next;
            default:  w_final = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= MD_IDLE;
            r_op      <= MD_MUL;
            r_cnt     <= '0;
            r_prod    <= '0;
            r_mcand   <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_result  <= '0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (w_accept) begin
                        r_op      <= w_op_in;
                        r_cnt     <= '0;
                        r_mcand   <= i_operand_a;
                        r_prod    <= {{DATA_WIDTH{1'b0}}, i_operand_b};
                        r_quot    <= i_operand_a;
                        r_rem     <= '0;
                        r_divisor <= i_operand_b;
                        // RISC-V divide-by-zero results need no iterations.
                        if (md_is_div(w_op_in) && (i_operand_b == '0)) begin
                            r_result <= (w_op_in == MD_DIVU) ? MD_DIV0_QUOT[DATA_WIDTH-1:0]
                                                             : i_operand_a;
                            r_state  <= MD_DONE;
                        end else begin
                            r_state  <= MD_CALC;
                        end
                    end
                end
                MD_CALC: begin
                    if (i_flush) begin
                        r_state <= MD_IDLE;
                    end else begin
                        r_prod <= w_prod_next;
                        r_quot <= w_quot_next;
                        r_rem  <= w_rem_next;
                        r_cnt  <= r_cnt + 1'b1;
                        if (r_cnt == LAST_ITER) begin
                            r_result <= w_final;
                            r_state  <= MD_DONE;
                        end
                    end
                end
                MD_DONE: r_state <= MD_IDLE;
                default: r_state <= MD_IDLE;
            endcase
        end
    end

    assign o_busy   = (r_state == MD_CALC) || (r_state == MD_DONE);
    assign o_stall  = w_accept || (r_state == MD_CALC);
    assign o_done   = (r_state == MD_DONE) && !i_flush;
    assign o_result = r_result;

endmodule

// File: tb/tb_ie_muldiv_sequencer.sv
// Directed bench for ie_muldiv_sequencer: latency, results, divide-by-zero, flush, ignored start, async reset.
module tb_ie_muldiv_sequencer;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_operand_a;
    logic [31:0] i_operand_b;
    logic        i_flush;
    logic        o_busy;
    logic        o_stall;
    logic        o_done;
    logic [31:0] o_result;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    ie_muldiv_sequencer dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_op        (i_op),
        .i_operand_a (i_operand_a),
        .i_operand_b (i_operand_b),
        .i_flush     (i_flush),
        .o_busy      (o_busy),
        .o_stall     (o_stall),
        .o_done      (o_done),
        .o_result    (o_result)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Issue one op from IDLE, wait for o_done, check latency, result and the cycle after.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_edges);
        int edges;
        i_start = 1'b1; i_op = op; i_operand_a = a; i_operand_b = b;
        #1;
        chk({tag, "_stall_req"}, {31'd0, o_stall}, 32'd1);
        tick();
        i_start = 1'b0;
        edges = 1;
        if (exp_edges > 1) chk({tag, "_stall_calc"}, {31'd0, o_stall}, 32'd1);
        while (!o_done && edges < 100) begin
            tick();
            edges++;
        end
        chk({tag, "_latency"}, edges, exp_edges);
        chk({tag, "_result"}, o_result, exp_res);
        chk({tag, "_stall_done"}, {31'd0, o_stall}, 32'd0);
        $display("op=%0d a=0x%08h b=0x%08h result=0x%08h edges=%0d", op, a, b, o_result, edges);
        tick();
        chk({tag, "_done_once"}, {31'd0, o_done}, 32'd0);
        chk({tag, "_idle"}, {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        int done_seen;
        i_reset = 1'b1; i_start = 1'b0; i_op = 2'd0;
        i_operand_a = '0; i_operand_b = '0; i_flush = 1'b0;
        #12;
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_stall", {31'd0, o_stall}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_result", o_result, 32'd0);
        tick();
        i_reset = 1'b0;
        tick();

        run_op("mul_7x6", 2'd0, 32'd7, 32'd6, 32'd42, 33);
        run_op("mulhu_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mul_ff", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
        run_op("mul_shift", 2'd0, 32'h1234_5678, 32'h10, 32'h2345_6780, 33);
        run_op("mulhu_shift", 2'd1, 32'h1234_5678, 32'h10, 32'h0000_0001, 33);
        run_op("divu_100_7", 2'd2, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu_100_7", 2'd3, 32'd100, 32'd7, 32'd2, 33);
        run_op("divu_ff_1", 2'd2, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
        run_op("divu_big_3", 2'd2, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 33);
        run_op("remu_big_3", 2'd3, 32'h8000_0000, 32'd3, 32'd2, 33);
        run_op("divu_5_0", 2'd2, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu_5_0", 2'd3, 32'd5, 32'd0, 32'd5, 1);

        // Flush at CALC iteration 10: back to IDLE, no done, result held at 5.
        i_start = 1'b1; i_op = 2'd2; i_operand_a = 32'd100; i_operand_b = 32'd7;
        tick();
        i_start = 1'b0;
        repeat (10) tick();
        i_flush = 1'b1;
        #1;
        chk("flush_done_mask", {31'd0, o_done}, 32'd0);
        tick();
        i_flush = 1'b0;
        chk("flush_idle", {31'd0, o_busy}, 32'd0);
        done_seen = 0;
        repeat (40) begin
            tick();
            if (o_done) done_seen++;
        end
        chk("flush_no_done", done_seen, 0);
        chk("flush_result_held", o_result, 32'd5);
        $display("flush at iteration 10: done_seen=%0d result=0x%08h", done_seen, o_result);

        // Start and flush together in IDLE: not accepted.
        i_start = 1'b1; i_flush = 1'b1; i_op = 2'd0; i_operand_a = 32'd3; i_operand_b = 32'd3;
        #1;
        chk("sf_stall", {31'd0, o_stall}, 32'd0);
        tick();
        i_start = 1'b0; i_flush = 1'b0;
        chk("sf_not_busy", {31'd0, o_busy}, 32'd0);
        $display("start+flush in IDLE: busy=%0d", o_busy);
        tick();

        // Start pulsed mid-CALC must not disturb the running MUL.
        i_start = 1'b1; i_op = 2'd0; i_operand_a = 32'd7; i_operand_b = 32'd6;
        tick();
        i_start = 1'b0;
        repeat (4) tick();
        i_start = 1'b1; i_op = 2'd2; i_operand_a = 32'd1; i_operand_b = 32'd0;
        tick();
        i_start = 1'b0;
        done_seen = 0;
        for (int e = 6; e <= 33; e++) begin
            if (o_done) done_seen++;
            if (e < 33) tick();
        end
        chk("ign_done_time", {31'd0, o_done}, 32'd1);
        chk("ign_early_done", done_seen, 1);
        chk("ign_result", o_result, 32'd42);
        tick();
        repeat (3) begin
            tick();
            chk("ign_no_queue", {31'd0, o_busy}, 32'd0);
        end
        $display("start during CALC ignored: result=0x%08h", o_result);

        // Async reset between edges mid-CALC.
        i_start = 1'b1; i_op = 2'd1; i_operand_a = 32'hFFFF_FFFF; i_operand_b = 32'd2;
        tick();
        i_start = 1'b0;
        repeat (8) tick();
        #2;
        i_reset = 1'b1;
        #1;
        chk("arst_busy", {31'd0, o_busy}, 32'd0);
        chk("arst_stall", {31'd0, o_stall}, 32'd0);
        chk("arst_result", o_result, 32'd0);
        $display("async reset mid-CALC: busy=%0d result=0x%08h", o_busy, o_result);
        tick();
        i_reset = 1'b0;
        done_seen = 0;
        repeat (3) begin
            tick();
            if (o_done) done_seen++;
        end
        chk("arst_no_done", done_seen, 0);
        run_op("divu_9_3", 2'd2, 32'd9, 32'd3, 32'd3, 33);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
